// File: rtl/lpddr2_bridge_pkg.sv
// Shared types and constants for the LPDDR2 Avalon-MM bridge.
// Holds the FSM state encoding and default sizing.
package lpddr2_bridge_pkg;

    localparam int BRIDGE_ADDR_W  = 27;
    localparam int BRIDGE_DATA_W  = 32;
    localparam int BRIDGE_TIMEOUT = 1023;

    localparam logic [31:0] BRIDGE_TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CMD  = 3'd1,
        RD_DATA = 3'd2,
        WR_CMD  = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/bridge_timeout.sv
// Saturating wait-state counter for the LPDDR2 bridge.
// expired_o is high once the count has reached TIMEOUT.
module bridge_timeout
    import lpddr2_bridge_pkg::*;
#(
    parameter int TIMEOUT = BRIDGE_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/lpddr2_avalon_bridge.sv
// CPU level-request port to LPDDR2 controller Avalon-MM bridge.
// One transaction per request assertion, bounded by a timeout.
module lpddr2_avalon_bridge
    import lpddr2_bridge_pkg::*;
#(
    parameter int ADDR_W  = BRIDGE_ADDR_W,
    parameter int DATA_W  = BRIDGE_DATA_W,
    parameter int TIMEOUT = BRIDGE_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic [DATA_W-1:0]   cpu_write_data,
    input  logic                cpu_rreq,
    input  logic                cpu_wreq,
    output logic [DATA_W-1:0]   cpu_read_data,
    output logic                cpu_ack,
    output logic                cpu_busy,
    output logic                cpu_error,
    input  logic                ctl_init_done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_burstcount,
    input  logic                avm_waitrequest,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_readdatavalid
);

    localparam logic [DATA_W-1:0] TO_DATA = DATA_W'(BRIDGE_TIMEOUT_DATA);

    bridge_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              to_clear, to_enable, to_expired;

    assign to_clear  = (state_d != state_q);
    assign to_enable = (state_q == RD_CMD) ||
                       (state_q == WR_CMD) ||
                       (state_q == RD_DATA);

    bridge_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (to_clear),
        .enable_i  (to_enable),
        .expired_o (to_expired)
    );

    // Next-state and datapath updates; a timeout aborts to ACK.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (ctl_init_done) begin
                    if (cpu_wreq) begin
                        addr_d  = cpu_address;
                        wdata_d = cpu_write_data;
                        state_d = WR_CMD;
                    end else if (cpu_rreq) begin
                        addr_d  = cpu_address;
                        state_d = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (!avm_waitrequest) begin
                    state_d = RD_DATA;
                end else if (to_expired) begin
                    rdata_d = TO_DATA;
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            WR_CMD: begin
                if (!avm_waitrequest) begin
                    state_d = ACK;
                end else if (to_expired) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            RD_DATA: begin
                if (avm_readdatavalid) begin
                    rdata_d = avm_readdata;
                    state_d = ACK;
                end else if (to_expired) begin
                    rdata_d = TO_DATA;
                    err_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!cpu_rreq && !cpu_wreq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, command and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign avm_read       = (state_q == RD_CMD);
    assign avm_write      = (state_q == WR_CMD);
    assign avm_address    = addr_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = '1;
    assign avm_burstcount = 1'b1;

    assign cpu_ack       = (state_q == ACK);
    assign cpu_busy      = (state_q != IDLE);
    assign cpu_error     = err_q;
    assign cpu_read_data = rdata_q;

endmodule
